// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB stage (A) has absolute priority, long-latency
// results (B) queue in a small FIFO, with a pending-write scoreboard and a starvation stall.
module rf_wport_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_we,
    input  logic [ADDR_W-1:0]             a_waddr,
    input  logic [DATA_W-1:0]             a_wdata,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [ADDR_W-1:0]             b_waddr,
    input  logic [DATA_W-1:0]             b_wdata,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_addr,
    input  logic [ADDR_W-1:0]             q_addr1,
    input  logic [ADDR_W-1:0]             q_addr2,
    output logic                          q_busy1,
    output logic                          q_busy2,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int SW     = $clog2(STARVE_MAX + 1);
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ARM = SW'(STARVE_MAX - 1);

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic [NREG-1:0]   pend, pend_nxt;

    logic              full, empty, a_req, push, pop, blocked, b_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign full      = (cnt == CNT_FULL);
    assign empty     = (cnt == '0);
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign a_req     = a_we && (a_waddr != '0);
    assign b_ready   = !rst && !full;
    assign push      = b_valid && b_ready;
    assign pop       = !rst && !a_req && !empty;
    assign blocked   = !empty && !pop;
    assign b_write   = pop && (head_addr != '0);
    assign fifo_cnt  = cnt;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (a_req) begin
                rf_we    = 1'b1;
                rf_waddr = a_waddr;
                rf_wdata = a_wdata;
            end else if (!empty) begin
                rf_we    = (head_addr != '0);
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
        end
    end

    // A same-cycle B write is not busy: the regfile forwards rf_wdata to ID.
    assign q_busy1 = !rst && pend[q_addr1] && (q_addr1 != '0) && !(b_write && head_addr == q_addr1);
    assign q_busy2 = !rst && pend[q_addr2] && (q_addr2 != '0) && !(b_write && head_addr == q_addr2);

    // Clear first, then set, so a same-cycle re-issue keeps the register pending.
    always_comb begin
        pend_nxt = pend;
        if (b_write)
            pend_nxt[head_addr] = 1'b0;
        if (iss_valid && (iss_addr != '0))
            pend_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= b_waddr;
            mem_data[wr_ptr] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            starve    <= '0;
            stall_req <= 1'b0;
            pend      <= '0;
        end else begin
            pend <= pend_nxt;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);

            if (!blocked)
                starve <= '0;
            else if (starve != STARVE_TOP)
                starve <= starve + SW'(1);

            if (pop)
                stall_req <= 1'b0;
            else if (blocked && starve == STARVE_ARM)
                stall_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: linear steps with hand-computed expectations.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  q_addr1, q_addr2;
    logic        q_busy1, q_busy2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [1:0]  fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wport_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .fifo_cnt(fifo_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
        b_valid = 1'b1; b_waddr = 5'd1; b_wdata = 32'h11;
        iss_valid = 1'b1; iss_addr = 5'd2; q_addr1 = 5'd2; q_addr2 = 5'd0;
        #1;
        // Test 1: reset with a B push and A request in flight
        chk("rst_b_ready", b_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_busy1", q_busy1, 0);
        tick(); tick();
        rst = 1'b0; a_we = 1'b0; b_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("t1_b_ready", b_ready, 1);
        chk("t1_cnt", fifo_cnt, 0);
        chk("t1_rf_we", rf_we, 0);
        chk("t1_busy1", q_busy1, 0);
        chk("t1_busy2", q_busy2, 0);
        chk("t1_stall", stall_req, 0);

        // Test 2: push r5 in cycle N, written in N+1
        tick();
        b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'hDEAD_BEEF;
        #1;
        chk("t2_nobypass_we", rf_we, 0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("t2_cnt1", fifo_cnt, 1);
        chk("t2_we", rf_we, 1);
        chk("t2_waddr", rf_waddr, 5);
        chk("t2_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_cnt0", fifo_cnt, 0);
        chk("t2_idle_we", rf_we, 0);

        // Test 3: A writes r3 every cycle while B fills and starves
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'hA0;
        #1;
        chk("t3_a_waddr", rf_waddr, 3);
        chk("t3_a_wdata", rf_wdata, 32'h33);
        tick();
        b_waddr = 5'd11; b_wdata = 32'hB0;
        #1;
        chk("t3_c2_cnt", fifo_cnt, 1);
        chk("t3_c2_ready", b_ready, 1);
        tick();
        b_waddr = 5'd12; b_wdata = 32'hC0;
        #1;
        chk("t3_full_cnt", fifo_cnt, 2);
        chk("t3_full_ready", b_ready, 0);
        chk("t3_a_wins", rf_waddr, 3);
        tick();
        chk("t3_c4_stall", stall_req, 0);
        tick();
        chk("t3_c5_stall", stall_req, 0);
        chk("t3_c5_cnt", fifo_cnt, 2);
        tick();
        a_we = 1'b0;
        #1;
        chk("t3_stall", stall_req, 1);
        chk("t3_pop1_we", rf_we, 1);
        chk("t3_pop1_addr", rf_waddr, 10);
        chk("t3_pop1_data", rf_wdata, 32'hA0);
        chk("t3_full_ready2", b_ready, 0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("t3_stall_clr", stall_req, 0);
        chk("t3_no_push_when_full", fifo_cnt, 1);
        chk("t3_pop2_addr", rf_waddr, 11);
        chk("t3_pop2_data", rf_wdata, 32'hB0);
        tick();
        chk("t3_empty", fifo_cnt, 0);
        chk("t3_empty_we", rf_we, 0);

        // Test 4: scoreboard on r7
        iss_valid = 1'b1; iss_addr = 5'd7; q_addr1 = 5'd7; q_addr2 = 5'd7;
        #1;
        chk("t4_not_yet", q_busy1, 0);
        tick();
        iss_valid = 1'b0;
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'h77;
        #1;
        chk("t4_busy1", q_busy1, 1);
        chk("t4_busy2", q_busy2, 1);
        tick();
        b_valid = 1'b0;
        #1;
        chk("t4_wr_addr", rf_waddr, 7);
        chk("t4_busy_fwd", q_busy1, 0);
        tick();
        chk("t4_cleared", q_busy1, 0);
        chk("t4_cleared2", q_busy2, 0);

        // Test 5: address-0 entries and r0 requests
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h55;
        iss_valid = 1'b1; iss_addr = 5'd0; q_addr1 = 5'd0;
        tick();
        b_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("t5_r0_cnt", fifo_cnt, 1);
        chk("t5_r0_we", rf_we, 0);
        chk("t5_r0_busy", q_busy1, 0);
        tick();
        chk("t5_r0_popped", fifo_cnt, 0);
        b_valid = 1'b1; b_waddr = 5'd4; b_wdata = 32'h44;
        tick();
        b_valid = 1'b0;
        a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'h99;
        #1;
        chk("t5_a0_we", rf_we, 1);
        chk("t5_a0_addr", rf_waddr, 4);
        chk("t5_a0_data", rf_wdata, 32'h44);
        tick();
        a_we = 1'b0;
        #1;
        chk("t5_a0_cnt", fifo_cnt, 0);

        // Test 6: re-issue to r9 in the cycle B writes r9
        iss_valid = 1'b1; iss_addr = 5'd9; q_addr1 = 5'd9;
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h90;
        tick();
        b_valid = 1'b0;
        #1;
        chk("t6_wr_addr", rf_waddr, 9);
        chk("t6_busy_fwd", q_busy1, 0);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("t6_set_wins", q_busy1, 1);

        // Reset mid-operation: queued entry and pending bit discarded
        a_we = 1'b1; a_waddr = 5'd3;
        b_valid = 1'b1; b_waddr = 5'd8; b_wdata = 32'h88;
        tick();
        b_valid = 1'b0;
        #1;
        chk("rm_cnt_before", fifo_cnt, 1);
        rst = 1'b1;
        #1;
        chk("rm_cnt", fifo_cnt, 0);
        chk("rm_busy", q_busy1, 0);
        chk("rm_rf_we", rf_we, 0);
        tick();
        rst = 1'b0; a_we = 1'b0;
        #1;
        chk("rm_pend_gone", q_busy1, 0);
        chk("rm_empty_we", rf_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
